// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch entry bundle, FSM state enum and default reset PC.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect, decode output.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_misaligned;

    modport master (
        output imem_req_valid, imem_addr,
        output out_valid, out_instruction,
        output out_pc, out_misaligned,
        input  imem_req_ready, imem_resp_valid,
        input  imem_resp_data, redirect_valid,
        input  redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        input  out_valid, out_instruction,
        input  out_pc, out_misaligned,
        output imem_req_ready, imem_resp_valid,
        output imem_resp_data, redirect_valid,
        output redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Ports: i_push/i_data, i_pop, i_flush, o_head, o_count, o_full, o_empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  fetch_entry_t         i_data,
    input  logic                 i_pop,
    input  logic                 i_flush,
    output fetch_entry_t         o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;

    assign o_count = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests, buffer, redirect flush.
// Ports: clk, rst_n, bus (fetch_if.master). Option: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    fetch_if.master bus
);

    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = ((OW > CW) ? OW : CW) + 1;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_req_pc;
    logic [31:0]  r_resp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [OW-1:0] w_out_nxt;
    logic [SW-1:0] w_sum;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic [31:0]   w_redir_pc;
    logic          w_redir;
    logic          w_resp;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_out_valid;
    logic          w_pop;
    logic          w_keep;
    logic          w_drop;
    logic          w_hold;
    logic          w_byp;

    assign w_redir = bus.redirect_valid;
    assign w_resp  = bus.imem_resp_valid;

    // Credits cover both in-flight requests and buffered entries.
    assign w_sum       = SW'(r_outstanding) + SW'(w_count);
    assign w_req_valid = rst_n && !w_redir && !w_hold &&
                         (w_sum < SW'(FIFO_DEPTH));
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_out_nxt   = r_outstanding + OW'(w_req_fire)
                       - OW'(w_resp);

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_req_pc;

    assign w_out_valid   = (!w_empty || w_byp) && !w_redir;
    assign bus.out_valid = w_out_valid;
    assign w_pop = w_out_valid && bus.out_ready && !w_byp;

    assign w_push_data.instruction = bus.imem_resp_data;
    assign w_push_data.pc          = r_resp_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stale responses count down in FLUSH; new ones queue behind them.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_redir && (w_out_nxt != '0)) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (w_redir) begin
                    w_state_nxt = (w_out_nxt != '0) ? FLUSH : RUN;
                end else if (w_resp && (r_drop_cnt == OW'(1))) begin
                    w_state_nxt = RUN;
                end
            end
        endcase
    end

    // A response in the redirect cycle is always stale.
    always_comb begin
        w_keep = 1'b0;
        w_drop = 1'b0;
        unique case (1'b1)
            w_redir: w_drop = 1'b0;
            (!w_redir && r_state == FLUSH): w_drop = w_resp;
            (!w_redir && r_state == RUN):   w_keep = w_resp;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pc      <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_redir) begin
                r_req_pc   <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_drop_cnt <= w_out_nxt;
            end else begin
                if (w_req_fire) begin
                    r_req_pc <= r_req_pc + 32'd4;
                end
                if (w_keep) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - OW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic        r_mis;
    logic        r_mis_pend;
    logic [31:0] r_mis_pc;

    assign w_redir_pc = bus.redirect_pc;
    assign w_hold     = r_mis;
    assign w_byp      = r_mis_pend;

    // Sticky flag blocks fetch; one nop entry reports the fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis      <= 1'b0;
            r_mis_pend <= 1'b0;
            r_mis_pc   <= '0;
        end else if (w_redir) begin
            r_mis      <= |bus.redirect_pc[1:0];
            r_mis_pend <= |bus.redirect_pc[1:0];
            r_mis_pc   <= bus.redirect_pc;
        end else if (r_mis_pend && w_out_valid && bus.out_ready) begin
            r_mis_pend <= 1'b0;
        end
    end

    assign bus.out_instruction = r_mis_pend ? NOP_INSTR
                                            : w_head.instruction;
    assign bus.out_pc          = r_mis_pend ? r_mis_pc : w_head.pc;
    assign bus.out_misaligned  = r_mis_pend;
`else
    assign w_redir_pc          = bus.redirect_pc & ~32'h3;
    assign w_hold              = 1'b0;
    assign w_byp               = 1'b0;
    assign bus.out_instruction = w_head.instruction;
    assign bus.out_pc          = w_head.pc;
    assign bus.out_misaligned  = 1'b0;
`endif

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(bus.imem_resp_valid && w_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a program-order stream model.
// Works with or without FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h100;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    mreq_t       mq[$];
    exp_t        eq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    logic [31:0] m_pc = RPC;
    logic        m_mis = 1'b0;
    logic        seen_zero = 1'b0;
    logic        c_rdy = 1'b1;
    logic        c_ordy = 1'b1;
    logic        c_redir = 1'b0;
    logic [31:0] c_rpc = '0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int n_stale();
        int n = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) n++;
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic        rv;
        logic        ov;
        logic        rfire;
        logic        ofire;
        logic        rsp;
        logic [31:0] faddr;
        mreq_t       h;
        @(negedge clk);
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_req_ready  = c_rdy;
        bus.out_ready       = c_ordy;
        bus.redirect_valid  = c_redir;
        bus.redirect_pc     = c_rpc;
        bus.imem_resp_valid = rsp;
        bus.imem_resp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
        #1;
        rv = !c_redir && !m_mis && (mq.size() + eq.size() < DEPTH);
        ov = !c_redir && (eq.size() > 0);
        check("req_valid", 32'(bus.imem_req_valid), 32'(rv));
        if (rv) check("req_addr", bus.imem_addr, m_pc);
        check("out_valid", 32'(bus.out_valid), 32'(ov));
        if (ov) begin
            check("out_pc", bus.out_pc, eq[0].pc);
            check("out_instr", bus.out_instruction, eq[0].instr);
            check("out_mis", 32'(bus.out_misaligned), 32'(eq[0].mis));
        end
        rfire = bus.imem_req_valid && c_rdy;
        ofire = bus.out_valid && c_ordy;
        faddr = bus.imem_addr;
        @(posedge clk);
        if (ofire && eq.size() > 0) void'(eq.pop_front());
        if (rsp) begin
            h = mq.pop_front();
            if (h.epoch == epoch && !c_redir)
                eq.push_back('{mem_word(h.addr), h.addr, 1'b0});
        end
        if (rfire) begin
            mq.push_back('{faddr, epoch, cyc + lat});
            if (faddr == 32'h0) seen_zero = 1'b1;
        end
        if (c_redir) begin
            eq.delete();
            epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc  = c_rpc;
            m_mis = |c_rpc[1:0];
            if (m_mis) eq.push_back('{NOP_INSTR, c_rpc, 1'b1});
`else
            m_pc = c_rpc & ~32'h3;
`endif
        end else if (rfire) begin
            m_pc = m_pc + 32'd4;
        end
        c_redir = 1'b0;
        cyc++;
    endtask

    task automatic do_reset(int hold);
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.redirect_valid  = 1'b0;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_instr", bus.out_instruction, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_mis", 32'(bus.out_misaligned), 0);
        mq.delete();
        eq.delete();
        epoch++;
        m_pc  = RPC;
        m_mis = 1'b0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect(logic [31:0] pc);
        c_redir = 1'b1;
        c_rpc   = pc;
        step();
    endtask

    task automatic wait_inflight(int n);
        for (int i = 0; i < 20 && mq.size() != n; i++) step();
        check("inflight", mq.size(), n);
    endtask

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b1;

        do_reset(2);
        lat = 1;
        repeat (12) step();

        c_ordy = 1'b0;
        repeat (10) step();
        c_ordy = 1'b1;
        repeat (8) step();

        lat = 3;
        wait_inflight(2);
        redirect(32'h200);
        for (int i = 0; i < 20 && n_stale() != 0; i++) step();
        repeat (12) step();
        check("drop_idle", 32'(dut.r_drop_cnt), 0);

        wait_inflight(2);
        redirect(32'h280);
        for (int i = 0; i < 10 && n_stale() != 1; i++) step();
        check("stale1", n_stale(), 1);
        redirect(32'h300);
        repeat (20) step();
        check("drop_idle2", 32'(dut.r_drop_cnt), 0);

        lat = 1;
        seen_zero = 1'b0;
        redirect(32'hFFFF_FFF4);
        repeat (10) step();
        check("wrap", 32'(seen_zero), 1);

        redirect(32'h202);
        c_ordy = 1'b0;
        repeat (5) step();
        c_ordy = 1'b1;
        repeat (5) step();
        redirect(32'h400);
        repeat (10) step();

        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 4);
            c_rdy  = ($urandom_range(0, 3) != 0);
            c_ordy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                c_redir = 1'b1;
                c_rpc   = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 7) == 0) c_rpc[1] = 1'b1;
            end
            step();
        end

        c_rdy  = 1'b1;
        c_ordy = 1'b1;
        lat    = 3;
        redirect(32'h800);
        repeat (2) step();
        do_reset(2);
        lat = 2;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
